// File: rtl/control_llenado_agua.sv
// rtl/control_llenado_agua.sv - water fill controller: debounced temperature select plus fill sequencer
//
// Purpose:
//   Debounces the front-panel temperature button and cycles the selection
//   Ambiente -> Caliente -> Tibia -> Fria. On a start request it runs a fill.
//   During the fill it drives the hot/cold valves for the selected temperature.
//   The fill ends when the level sensor trips, the timeout expires, or the user aborts.
//
// Optional feature macro: MIX_ALTERNATE_EN
//   defined   : Tibia alternates hot/cold every MIX_PERIOD/2 cycles, hot half first.
//   undefined : Tibia opens both valves continuously; no phase counter.
//
// Ports:
//   iClk                 system clock (rising edge)
//   iReset_Temperatura   asynchronous active-low reset
//   iBoton_Temperatura   raw bouncing select button, high = pressed
//   iInicio              start request, synchronous
//   iAbortar             abort, synchronous
//   iNivel_Lleno         asynchronous tank-full sensor, high = full
//   oEstado_Temp[1:0]    selection: 00 Ambiente, 01 Caliente, 10 Tibia, 11 Fria
//   oAgua_Caliente       hot valve enable (registered)
//   oAgua_Fria           cold valve enable (registered)
//   oLlenando            high while filling
//   oListo               one-cycle pulse after a fill completes on level
//   oFalla               high while in fault (fill timeout)

module control_llenado_agua #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MIX_PERIOD      = 8,
  parameter int FILL_TIMEOUT    = 64
) (
  input  logic       iClk,
  input  logic       iReset_Temperatura,
  input  logic       iBoton_Temperatura,
  input  logic       iInicio,
  input  logic       iAbortar,
  input  logic       iNivel_Lleno,
  output logic [1:0] oEstado_Temp,
  output logic       oAgua_Caliente,
  output logic       oAgua_Fria,
  output logic       oLlenando,
  output logic       oListo,
  output logic       oFalla
);

  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int FILL_W = $clog2(FILL_TIMEOUT);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(FILL_TIMEOUT - 1);

`ifdef MIX_ALTERNATE_EN
  localparam int PH_W = $clog2(MIX_PERIOD);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(MIX_PERIOD - 1);
  localparam logic [PH_W-1:0] PH_HALF = PH_W'(MIX_PERIOD / 2);
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               boton_s1_q, boton_s1_d;
  logic               boton_s2_q, boton_s2_d;
  logic               deb_level_q, deb_level_d;
  logic               deb_prev_q, deb_prev_d;
  logic [DEB_W-1:0]   deb_cnt_q, deb_cnt_d;
  logic               press_q, press_d;
  logic               nivel_s1_q, nivel_s1_d;
  logic               nivel_s2_q, nivel_s2_d;
  logic [1:0]         sel_q, sel_d;
  logic               hot_q, hot_d;
  logic               cold_q, cold_d;
  logic               listo_q, listo_d;
  logic [FILL_W-1:0]  fill_cnt_q, fill_cnt_d;
`ifdef MIX_ALTERNATE_EN
  logic [PH_W-1:0]    phase_q, phase_d;
`endif

  always_comb begin
    boton_s1_d  = iBoton_Temperatura;
    boton_s2_d  = boton_s1_q;
    nivel_s1_d  = iNivel_Lleno;
    nivel_s2_d  = nivel_s1_q;

    // Debounce: count consecutive samples that disagree with the accepted
    // level; the last of DEBOUNCE_CYCLES such samples flips it.
    deb_level_d = deb_level_q;
    deb_cnt_d   = '0;
    if (boton_s2_q != deb_level_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        deb_level_d = ~deb_level_q;
      end else begin
        deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end
    end
    deb_prev_d  = deb_level_q;
    press_d     = deb_level_q & ~deb_prev_q;

    // Presses while filling are dropped, never deferred.
    sel_d = sel_q;
    if (press_q && (state_q != ST_FILL)) begin
      sel_d = sel_q + 2'd1;
    end

    state_d    = state_q;
    listo_d    = 1'b0;
    fill_cnt_d = fill_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (iInicio && !iAbortar && !nivel_s2_q) begin
          state_d    = ST_FILL;
          fill_cnt_d = '0;
        end
      end
      ST_FILL: begin
        if (iAbortar) begin
          state_d = ST_IDLE;
        end else if (nivel_s2_q) begin
          state_d = ST_IDLE;
          listo_d = 1'b1;
        end else if (fill_cnt_q == FILL_LAST) begin
          state_d = ST_FAULT;
        end else begin
          fill_cnt_d = fill_cnt_q + FILL_W'(1);
        end
      end
      ST_FAULT: begin
        if (iAbortar) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef MIX_ALTERNATE_EN
    phase_d = phase_q;
    if ((state_q != ST_FILL) && (state_d == ST_FILL)) begin
      phase_d = '0;
    end else if (state_q == ST_FILL) begin
      phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
    end
`endif

    // Valves are computed from the next state so they switch on the same
    // edge that enters or leaves FILL.
    hot_d  = 1'b0;
    cold_d = 1'b0;
    if (state_d == ST_FILL) begin
      case (sel_d)
        2'b00: begin hot_d = 1'b1; cold_d = 1'b1; end
        2'b01: begin hot_d = 1'b1; cold_d = 1'b0; end
        2'b11: begin hot_d = 1'b0; cold_d = 1'b1; end
        default: begin
`ifdef MIX_ALTERNATE_EN
          hot_d  = (phase_d < PH_HALF);
          cold_d = ~(phase_d < PH_HALF);
`else
          hot_d  = 1'b1;
          cold_d = 1'b1;
`endif
        end
      endcase
    end
  end

  always_ff @(posedge iClk or negedge iReset_Temperatura) begin
    if (!iReset_Temperatura) begin
      state_q     <= ST_IDLE;
      boton_s1_q  <= 1'b0;
      boton_s2_q  <= 1'b0;
      deb_level_q <= 1'b0;
      deb_prev_q  <= 1'b0;
      deb_cnt_q   <= '0;
      press_q     <= 1'b0;
      nivel_s1_q  <= 1'b0;
      nivel_s2_q  <= 1'b0;
      sel_q       <= 2'b00;
      hot_q       <= 1'b0;
      cold_q      <= 1'b0;
      listo_q     <= 1'b0;
      fill_cnt_q  <= '0;
`ifdef MIX_ALTERNATE_EN
      phase_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      boton_s1_q  <= boton_s1_d;
      boton_s2_q  <= boton_s2_d;
      deb_level_q <= deb_level_d;
      deb_prev_q  <= deb_prev_d;
      deb_cnt_q   <= deb_cnt_d;
      press_q     <= press_d;
      nivel_s1_q  <= nivel_s1_d;
      nivel_s2_q  <= nivel_s2_d;
      sel_q       <= sel_d;
      hot_q       <= hot_d;
      cold_q      <= cold_d;
      listo_q     <= listo_d;
      fill_cnt_q  <= fill_cnt_d;
`ifdef MIX_ALTERNATE_EN
      phase_q     <= phase_d;
`endif
    end
  end

  assign oEstado_Temp   = sel_q;
  assign oAgua_Caliente = hot_q;
  assign oAgua_Fria     = cold_q;
  assign oLlenando      = (state_q == ST_FILL);
  assign oListo         = listo_q;
  assign oFalla         = (state_q == ST_FAULT);

endmodule

// File: tb/tb_control_llenado_agua.sv
// tb/tb_control_llenado_agua.sv - scoreboard bench for control_llenado_agua

module tb_control_llenado_agua;

  localparam int MIX  = 8;
  localparam int TOUT = 64;
`ifdef MIX_ALTERNATE_EN
  localparam bit ALT_EN = 1'b1;
`else
  localparam bit ALT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rstn, boton, inicio, abortar, nivel;
  logic [1:0] estado;
  logic       hot, cold, llen, listo, falla;

  control_llenado_agua dut (
    .iClk               (clk),
    .iReset_Temperatura (rstn),
    .iBoton_Temperatura (boton),
    .iInicio            (inicio),
    .iAbortar           (abortar),
    .iNivel_Lleno       (nivel),
    .oEstado_Temp       (estado),
    .oAgua_Caliente     (hot),
    .oAgua_Fria         (cold),
    .oLlenando          (llen),
    .oListo             (listo),
    .oFalla             (falla)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [6:0] vec;
  } ev_t;

  ev_t        exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         m_sel = 0;
  bit         m_fault = 1'b0;
  bit         mon_en = 1'b0;
  logic [6:0] prev = 7'b0;

  // Output snapshot: {sel, hot, cold, filling, done, fault}
  function automatic logic [6:0] mk(int sel, logic [1:0] hc, bit ll, bit li, bit fa);
    logic [1:0] s;
    s = sel[1:0];
    return {s, hc, ll, li, fa};
  endfunction

  // {hot, cold} for a selection, ph cycles after FILL entry
  function automatic logic [1:0] pattern(int sel, int ph);
    bit hot_half;
    hot_half = (ph % MIX) < (MIX / 2);
    case (sel)
      0: return 2'b11;
      1: return 2'b10;
      3: return 2'b01;
      default: return ALT_EN ? (hot_half ? 2'b10 : 2'b01) : 2'b11;
    endcase
  endfunction

  task automatic push(int c, logic [6:0] v);
    ev_t e;
    e.cyc = c;
    e.vec = v;
    exp_q.push_back(e);
  endtask

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Monitor: every change of the output snapshot must match the next
  // expected event, both in cycle and value.
  always @(negedge clk) begin
    logic [6:0] cur;
    ev_t        e;
    if (mon_en) begin
      cur = {estado, hot, cold, llen, listo, falla};
      if (cur !== prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_change cyc=%0d got=%b required=no change (prev %b)", cyc, cur, prev);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (e.cyc != cyc) begin
            errors++;
            $display("FAIL event_cycle got=%0d required=%0d (value %b)", cyc, e.cyc, e.vec);
          end
          checks++;
          if (cur !== e.vec) begin
            errors++;
            $display("FAIL event_value cyc=%0d got=%b required=%b", cyc, cur, e.vec);
          end
        end
      end
      prev = cur;
    end
  end

  // One button press; the selection moves 7 edges after the first edge that
  // samples the final stable-high run of the raw input.
  task automatic press(bit bounce, int hold, int gap, bit counts);
    int first;
    if (bounce) begin
      boton = 1'b1; tick();
      boton = 1'b0; tick();
      boton = 1'b1;
    end else begin
      boton = 1'b1;
    end
    first = cyc + 1;
    if (counts) begin
      m_sel = (m_sel + 1) % 4;
      push(first + 7, mk(m_sel, 2'b00, 1'b0, 1'b0, m_fault));
    end
    tick(hold);
    boton = 1'b0;
    tick(gap);
  endtask

  task automatic set_sel(int s);
    int n;
    n = (s - m_sel + 4) % 4;
    repeat (n) press(1'($urandom_range(0, 1)), $urandom_range(4, 10), $urandom_range(6, 10), 1'b1);
  endtask

  // mode 0: level after L cycles; 1: timeout; 2: press, then abort with level; 3: reset after L cycles
  task automatic fill(int mode, int L);
    int E, X, sel;
    sel = m_sel;
    E = cyc + 1;
    case (mode)
      0:       X = E + L + 3;
      1:       X = E + TOUT;
      2:       X = E + 17;
      default: X = E + L;
    endcase
    push(E, mk(sel, pattern(sel, 0), 1'b1, 1'b0, 1'b0));
    for (int t = 1; t < X - E; t++)
      if (pattern(sel, t) != pattern(sel, t - 1))
        push(E + t, mk(sel, pattern(sel, t), 1'b1, 1'b0, 1'b0));
    case (mode)
      0: begin
        push(X, mk(sel, 2'b00, 1'b0, 1'b1, 1'b0));
        push(X + 1, mk(sel, 2'b00, 1'b0, 1'b0, 1'b0));
      end
      1:       push(X, mk(sel, 2'b00, 1'b0, 1'b0, 1'b1));
      2:       push(X, mk(sel, 2'b00, 1'b0, 1'b0, 1'b0));
      default: push(X, mk(0, 2'b00, 1'b0, 1'b0, 1'b0));
    endcase
    inicio = 1'b1; tick(); inicio = 1'b0;
    case (mode)
      0: begin
        tick(L);
        nivel = 1'b1;
        tick(3);
        nivel = 1'b0;
        tick(5);
      end
      1: begin
        tick(TOUT);
        m_fault = 1'b1;
        press(1'b0, 10, 10, 1'b1);
        inicio = 1'b1; tick(); inicio = 1'b0;
        tick(3);
        abortar = 1'b1;
        push(cyc + 1, mk(m_sel, 2'b00, 1'b0, 1'b0, 1'b0));
        tick();
        abortar = 1'b0;
        m_fault = 1'b0;
        tick(3);
      end
      2: begin
        boton = 1'b1; tick(10);
        boton = 1'b0; tick(4);
        nivel = 1'b1; tick(2);
        abortar = 1'b1; tick();
        abortar = 1'b0;
        nivel = 1'b0;
        tick(8);
      end
      default: begin
        tick(L);
        rstn = 1'b0;
        #1;
        checks++;
        if ({hot, cold, llen} !== 3'b000) begin
          errors++;
          $display("FAIL async_reset_valves got=%b required=000", {hot, cold, llen});
        end
        checks++;
        if (estado !== 2'b00) begin
          errors++;
          $display("FAIL async_reset_sel got=%b required=00", estado);
        end
        #1;
        rstn = 1'b1;
        m_sel = 0;
        tick(4);
      end
    endcase
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; boton = 1'b0; inicio = 1'b0; abortar = 1'b0; nivel = 1'b0;
    tick(3);
    checks++;
    if ({estado, hot, cold, llen, listo, falla} !== 7'b0) begin
      errors++;
      $display("FAIL reset_state got=%b required=0000000", {estado, hot, cold, llen, listo, falla});
    end
    rstn = 1'b1;
    prev = 7'b0;
    mon_en = 1'b1;
    tick(3);

    // Clean presses 00->01->10->11->00, then a bouncing press
    repeat (4) press(1'b0, 10, 10, 1'b1);
    press(1'b1, 10, 10, 1'b1);

    // Caliente fill ended by the level sensor
    set_sel(1);
    fill(0, 20);

    // Tibia fill that times out; press and start in FAULT, abort clears
    set_sel(2);
    fill(1, 0);

    // Ambiente fill: press ignored, abort beats level
    set_sel(0);
    fill(2, 0);

    // Start ignored with the tank full, and when aborted in the same cycle
    nivel = 1'b1; tick(4);
    inicio = 1'b1; tick(); inicio = 1'b0;
    tick(2); nivel = 1'b0; tick(4);
    inicio = 1'b1; abortar = 1'b1; tick();
    inicio = 1'b0; abortar = 1'b0; tick(3);

    // Randomized fills
    for (int i = 0; i < 10; i++) begin
      set_sel($urandom_range(0, 3));
      fill(0, $urandom_range(3, 55));
    end

    // Reset mid-fill
    set_sel(2);
    fill(3, 9);

    tick(20);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_events got=%0d required=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_llenado_agua.md
# control_llenado_agua

Clocked fill controller for the water-temperature datapath. It debounces the temperature-select button and cycles the selection Ambiente → Caliente → Tibia → Fria. On a start request it sequences a fill: it drives the hot/cold valves for the selected temperature until the level sensor trips, a timeout expires, or the user aborts. It sits between the front-panel button/level sensor and the valve drivers, and reports busy, done and fault to the appliance top level.

## Interface
- DEBOUNCE_CYCLES, 4: consecutive stable samples required to accept a button level change (≥2).
- MIX_PERIOD, 8: Tibia hot/cold alternation period in cycles (even, ≥2).
- FILL_TIMEOUT, 64: maximum FILL duration in cycles before fault (≥4).
- iClk  input  1  system clock; all state updates on its rising edge.
- iReset_Temperatura  input  1  reset, asynchronous, active-low.
- iBoton_Temperatura  input  1  raw, asynchronous, bouncing select button (high = pressed).
- iInicio  input  1  synchronous start request, sampled each cycle.
- iAbortar  input  1  synchronous abort, sampled each cycle.
- iNivel_Lleno  input  1  asynchronous tank-full sensor (high = full).
- oEstado_Temp  output  2  selection: 00 Ambiente, 01 Caliente, 10 Tibia, 11 Fria.
- oAgua_Caliente  output  1  hot valve enable, registered.
- oAgua_Fria  output  1  cold valve enable, registered.
- oLlenando  output  1  high while in FILL.
- oListo  output  1  one-cycle pulse on successful fill completion.
- oFalla  output  1  high while in FAULT.

## Operation
- Reset values (async, immediate): state IDLE, oEstado_Temp=00, both valves 0, oLlenando=0, oListo=0, oFalla=0. All counters and synchronizers are cleared; the debounced button level is 0.
- Button path:
  - Two-flop synchronizer, then a debounce counter.
  - The debounced level flips after DEBOUNCE_CYCLES consecutive synchronized samples differ from it.
  - Any agreeing sample clears the counter.
  - A rising edge of the debounced level produces a one-cycle press pulse.
- Selection:
  - A press pulse increments oEstado_Temp modulo 4 (11 wraps to 00), only in IDLE or FAULT.
  - Presses during FILL are discarded, not queued.
- iNivel_Lleno passes through a two-flop synchronizer (nivel_s).
- FSM states are IDLE, FILL and FAULT.
  - IDLE → FILL when iInicio=1, iAbortar=0 and nivel_s=0. iInicio is ignored if the tank is already full; no oListo is produced in that case.
  - FILL → IDLE with an oListo pulse when nivel_s=1.
  - FILL → FAULT when the fill counter reaches FILL_TIMEOUT-1 with nivel_s=0.
  - FILL → IDLE, no oListo, when iAbortar=1.
  - FAULT → IDLE only when iAbortar=1. iInicio is ignored in FAULT.
  - Priority in FILL: iAbortar > nivel_s > timeout.
- Valve pattern in FILL (valves are 0 in every other state):
  - Ambiente: hot=1, cold=1.
  - Caliente: hot=1, cold=0.
  - Fria: hot=0, cold=1.
  - Tibia: see Configuration.
- Phase counter:
  - Counts 0..MIX_PERIOD-1 and wraps.
  - Cleared on FILL entry.
- Fill counter:
  - Cleared on FILL entry and increments each FILL cycle.
  - Width is clog2(FILL_TIMEOUT); it never wraps.

## Timing
- Valves and oLlenando update on the same edge that registers the FILL entry: iInicio high at edge N gives valves and oLlenando at N.
- The exit edge (level, abort or timeout) clears the valves and oLlenando on that edge. oListo is high for exactly the cycle following the exit edge.
- Level latency: 2 edges of sync plus 1 edge for the FSM. With iNivel_Lleno rising before edge K, the valves close at edge K+2.
- FILL lasts at most FILL_TIMEOUT cycles. With defaults, FAULT is entered on the 64th FILL edge.
- Button latency with a clean press: oEstado_Temp changes DEBOUNCE_CYCLES+3 edges after the first edge that samples the raw input high. That is 7 edges with defaults.
- Reset asserted mid-FILL closes both valves immediately, without waiting for a clock edge.

## Configuration
- Macro MIX_ALTERNATE_EN.
  - Defined: Tibia alternates. hot=1, cold=0 while phase < MIX_PERIOD/2; hot=0, cold=1 otherwise. The hot half comes first after FILL entry.
  - Undefined: Tibia drives hot=1, cold=1 continuously. The phase counter is not instantiated.

## Test plan
- Reset, then three clean presses (each held 10 cycles, 10 cycles apart) → oEstado_Temp 00→01→10→11; a fourth press → 00; each change lands 7 edges after the press.
- Bouncing press (raw toggles every cycle for 3 cycles, then held high 10 cycles) → exactly one increment.
- Sel=01, iInicio pulse, iNivel_Lleno raised 20 cycles later → hot=1/cold=0 for the fill; valves close 2 edges after the level rises; a single oListo pulse; state IDLE.
- Sel=10 with MIX_ALTERNATE_EN defined, level never rises → hot/cold alternate 4/4 cycles starting hot; FAULT after 64 FILL cycles with valves 0 and oFalla=1; iAbortar clears to IDLE.
- Sel=00 fill; a button press, then iAbortar and the synchronized level asserted in the same cycle → press ignored (oEstado_Temp stays 00); abort wins with no oListo; both valves 0.
- iReset_Temperatura pulsed low mid-FILL between clock edges → valves and oLlenando drop immediately; oEstado_Temp=00.
